// File: rtl/sad_accumulate.sv
// ---------------------------------------------------------------------------
// sad_accumulate
//
// Purpose:
//   Sum-of-absolute-differences engine for a 4x4 block matched against 16
//   candidate positions. After a start request the block accepts 256 pixel
//   beats in candidate-major order: 16 beats for candidate 0, then 16 for
//   candidate 1, and so on. Each beat adds |cur - ref| to the working
//   accumulator of its candidate. When the final beat is accepted, all 16
//   results are copied to the registered sum outputs and done pulses for
//   one cycle.
//
// Ports:
//   i_clk          single clock, rising-edge active
//   i_rst          asynchronous active-high reset
//   i_start        begin a 16-candidate search (honoured only when idle)
//   i_abort        cancel a search in progress (honoured only while accumulating)
//   i_pix_valid    beat on i_cur_pix / i_ref_pix is valid
//   o_pix_ready    block accepts beats (state decode only, no path from valid)
//   i_cur_pix      current-block pixel
//   i_ref_pix      reference-window pixel
//   o_sum0..15     registered SAD per candidate, index = {dy[1:0], dx[1:0]}
//   o_done         one-cycle pulse: sums were just updated
//   o_busy         high while accumulating or finishing
// ---------------------------------------------------------------------------
module sad_accumulate #(
  parameter  int PIX_W = 8,
  localparam int SUM_W = PIX_W + 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_pix_valid,
  output logic             o_pix_ready,
  input  logic [PIX_W-1:0] i_cur_pix,
  input  logic [PIX_W-1:0] i_ref_pix,
  output logic [SUM_W-1:0] o_sum0,
  output logic [SUM_W-1:0] o_sum1,
  output logic [SUM_W-1:0] o_sum2,
  output logic [SUM_W-1:0] o_sum3,
  output logic [SUM_W-1:0] o_sum4,
  output logic [SUM_W-1:0] o_sum5,
  output logic [SUM_W-1:0] o_sum6,
  output logic [SUM_W-1:0] o_sum7,
  output logic [SUM_W-1:0] o_sum8,
  output logic [SUM_W-1:0] o_sum9,
  output logic [SUM_W-1:0] o_sum10,
  output logic [SUM_W-1:0] o_sum11,
  output logic [SUM_W-1:0] o_sum12,
  output logic [SUM_W-1:0] o_sum13,
  output logic [SUM_W-1:0] o_sum14,
  output logic [SUM_W-1:0] o_sum15,
  output logic             o_done,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [7:0]       r_cnt;
  logic [SUM_W-1:0] r_accWork [16];
  logic [SUM_W-1:0] r_sum     [16];
  logic [SUM_W-1:0] w_accNext [16];

  logic             w_xfer;
  logic             w_lastBeat;
  logic [3:0]       w_cand;
  logic [PIX_W-1:0] w_absDiff;

  assign w_xfer     = (r_state == S_ACC) && i_pix_valid;
  assign w_lastBeat = w_xfer && (r_cnt == 8'hFF);
  assign w_cand     = r_cnt[7:4];
  assign w_absDiff  = (i_cur_pix >= i_ref_pix) ? (i_cur_pix - i_ref_pix)
                                               : (i_ref_pix - i_cur_pix);

  // Working accumulators as they will be after this cycle's beat. The same
  // values feed the sum outputs on the last beat, so the final contribution
  // is already included when done is raised.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_accNext[i] = r_accWork[i];
      if (w_xfer && (w_cand == 4'(i))) begin
        w_accNext[i] = r_accWork[i] + {{(SUM_W - PIX_W){1'b0}}, w_absDiff};
      end
    end
  end

  // Next-state logic. Abort takes priority over a beat arriving in the same
  // cycle, so a search cancelled on its last beat never reaches DONE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_nextState = S_ACC;
      end
      S_ACC: begin
        if (i_abort)         w_nextState = S_IDLE;
        else if (w_lastBeat) w_nextState = S_DONE;
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // State, beat counter, working accumulators and published sums. The sum
  // registers are written only on the edge that enters DONE, so they hold
  // the previous results throughout any later (or aborted) search.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      for (int i = 0; i < 16; i++) begin
        r_accWork[i] <= '0;
        r_sum[i]     <= '0;
      end
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cnt <= '0;
            for (int i = 0; i < 16; i++) begin
              r_accWork[i] <= '0;
            end
          end
        end
        S_ACC: begin
          if (!i_abort && w_xfer) begin
            r_cnt <= r_cnt + 8'd1;
            for (int i = 0; i < 16; i++) begin
              r_accWork[i] <= w_accNext[i];
            end
            if (w_lastBeat) begin
              for (int i = 0; i < 16; i++) begin
                r_sum[i] <= w_accNext[i];
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake and status outputs decode the registered state only.
  assign o_pix_ready = (r_state == S_ACC);
  assign o_done      = (r_state == S_DONE);
  assign o_busy      = (r_state != S_IDLE);

  assign o_sum0  = r_sum[0];
  assign o_sum1  = r_sum[1];
  assign o_sum2  = r_sum[2];
  assign o_sum3  = r_sum[3];
  assign o_sum4  = r_sum[4];
  assign o_sum5  = r_sum[5];
  assign o_sum6  = r_sum[6];
  assign o_sum7  = r_sum[7];
  assign o_sum8  = r_sum[8];
  assign o_sum9  = r_sum[9];
  assign o_sum10 = r_sum[10];
  assign o_sum11 = r_sum[11];
  assign o_sum12 = r_sum[12];
  assign o_sum13 = r_sum[13];
  assign o_sum14 = r_sum[14];
  assign o_sum15 = r_sum[15];

endmodule

// File: tb/tb_sad_accumulate.sv
// ---------------------------------------------------------------------------
// tb_sad_accumulate
//
// Directed bench for sad_accumulate. Inputs change 1 time unit after each
// rising edge and outputs are observed at the same point. Latency is the
// number of rising edges from the edge that accepted start to the first edge
// at which a synchronous consumer sees done high.
// ---------------------------------------------------------------------------
module tb_sad_accumulate;

  localparam int PIX_W = 8;
  localparam int SUM_W = PIX_W + 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             pixValid;
  logic [PIX_W-1:0] curPix;
  logic [PIX_W-1:0] refPix;
  wire              pixReady;
  wire              done;
  wire              busy;
  wire  [SUM_W-1:0] sums [16];

  int errors = 0;
  int checks = 0;

  int doneEdge;
  int donePulses;
  int busyAfterDone;

  always #5 clk = ~clk;

  sad_accumulate #(.PIX_W(PIX_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_abort     (abort),
    .i_pix_valid (pixValid),
    .o_pix_ready (pixReady),
    .i_cur_pix   (curPix),
    .i_ref_pix   (refPix),
    .o_sum0      (sums[0]),
    .o_sum1      (sums[1]),
    .o_sum2      (sums[2]),
    .o_sum3      (sums[3]),
    .o_sum4      (sums[4]),
    .o_sum5      (sums[5]),
    .o_sum6      (sums[6]),
    .o_sum7      (sums[7]),
    .o_sum8      (sums[8]),
    .o_sum9      (sums[9]),
    .o_sum10     (sums[10]),
    .o_sum11     (sums[11]),
    .o_sum12     (sums[12]),
    .o_sum13     (sums[13]),
    .o_sum14     (sums[14]),
    .o_sum15     (sums[15]),
    .o_done      (done),
    .o_busy      (busy)
  );

  // Beat patterns, one per test: {cur, ref} for a given candidate.
  //   0: cur=ref=0x5A       1: cur=255 ref=0     2: cur=100 ref=100-c
  //   3: cur=10 ref=7       4: cur=3 ref=3+2c (ref above cur)
  function automatic logic [15:0] beatPix(input int mode, input int cand);
    case (mode)
      0:       return {8'h5A, 8'h5A};
      1:       return {8'hFF, 8'h00};
      2:       return {8'd100, 8'(100 - cand)};
      3:       return {8'd10, 8'd7};
      default: return {8'd3, 8'(3 + 2 * cand)};
    endcase
  endfunction

  // Hand-derived SAD per candidate for a complete 16-beat block.
  function automatic int expSum(input int mode, input int cand);
    case (mode)
      0:       return 0;
      1:       return 4080;
      2:       return 16 * cand;
      3:       return 48;
      default: return 32 * cand;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then move to 1 unit after the next edge.
  task automatic applyStimulus(input logic s, input logic a, input logic v,
                               input logic [PIX_W-1:0] c,
                               input logic [PIX_W-1:0] r);
    start    = s;
    abort    = a;
    pixValid = v;
    curPix   = c;
    refPix   = r;
    @(posedge clk);
    #1;
  endtask

  // Stream nBeats beats of a pattern starting right after the start edge,
  // then idle 4 cycles, tracking done pulses, latency and busy after done.
  task automatic runSearch(input int mode, input bit toggle, input int nBeats,
                           input bit spam);
    int edges = 0;
    int beat  = 0;
    logic [15:0] px;
    bit v;
    doneEdge      = -1;
    donePulses    = 0;
    busyAfterDone = -1;
    while (beat < nBeats && edges < 2000) begin
      v  = toggle ? (edges % 2 == 0) : 1'b1;
      px = beatPix(mode, beat / 16);
      applyStimulus(spam && (edges % 5 == 2), 1'b0, v, px[15:8], px[7:0]);
      edges++;
      if (v) beat++;
      if (done === 1'b1) begin
        donePulses++;
        if (doneEdge < 0) doneEdge = edges + 1;
      end
      if (doneEdge >= 0 && edges == doneEdge) busyAfterDone = int'(busy);
    end
    repeat (4) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      edges++;
      if (done === 1'b1) begin
        donePulses++;
        if (doneEdge < 0) doneEdge = edges + 1;
      end
      if (doneEdge >= 0 && edges == doneEdge) busyAfterDone = int'(busy);
    end
  endtask

  task automatic checkSums(input string name, input int mode);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("%s_sum%0d", name, i), 32'(sums[i]),
                  32'(expSum(mode, i)));
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    pixValid = 1'b0;
    curPix   = '0;
    refPix   = '0;
    #12;
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(pixReady), 32'd0);
    checkOutput("rst_sum0", 32'(sums[0]), 32'd0);
    checkOutput("rst_sum15", 32'(sums[15]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle with valid high: no ready, no busy.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h11, 8'h22);
    checkOutput("idle_ready", 32'(pixReady), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Zero-difference search, started with abort also high (start wins).
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_ready", 32'(pixReady), 32'd1);
    runSearch(0, 1'b0, 256, 1'b0);
    checkOutput("t1_latency", 32'(doneEdge), 32'd257);
    checkOutput("t1_pulses", 32'(donePulses), 32'd1);
    checkSums("t1", 0);

    // Maximum difference on every beat.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    runSearch(1, 1'b0, 256, 1'b0);
    checkOutput("t2_latency", 32'(doneEdge), 32'd257);
    checkOutput("t2_pulses", 32'(donePulses), 32'd1);
    checkOutput("t2_busy_after_done", 32'(busyAfterDone), 32'd0);
    checkSums("t2", 1);

    // Search aborted after 100 beats, abort cycle carrying a valid beat.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    runSearch(0, 1'b0, 100, 1'b0);
    checkOutput("t3_pulses", 32'(donePulses), 32'd0);
    checkOutput("t3_busy_mid", 32'(busy), 32'd1);
    checkOutput("t3_sum5_mid", 32'(sums[5]), 32'd4080);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A, 8'h5A);
    checkOutput("t3_busy_abort", 32'(busy), 32'd0);
    checkOutput("t3_done_abort", 32'(done), 32'd0);
    checkOutput("t3_ready_abort", 32'(pixReady), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A, 8'h5A);
    checkOutput("t3_done_after", 32'(done), 32'd0);
    checkSums("t3", 1);

    // Per-candidate differences with valid low every other cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    runSearch(2, 1'b1, 256, 1'b0);
    checkOutput("t4_latency", 32'(doneEdge), 32'd512);
    checkOutput("t4_pulses", 32'(donePulses), 32'd1);
    checkSums("t4", 2);

    // Reset in the middle of a search (after 130 beats), away from the edge.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    runSearch(1, 1'b0, 130, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_ready", 32'(pixReady), 32'd0);
    checkOutput("t5_rst_done", 32'(done), 32'd0);
    checkSums("t5_rst", 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd10, 8'd7);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd10, 8'd7);
    checkOutput("t5_wait_busy", 32'(busy), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    runSearch(3, 1'b0, 256, 1'b0);
    checkOutput("t5_latency", 32'(doneEdge), 32'd257);
    checkSums("t5", 3);

    // Repeated start pulses during accumulation; ref above cur on every beat.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    runSearch(4, 1'b0, 256, 1'b1);
    checkOutput("t6_latency", 32'(doneEdge), 32'd257);
    checkOutput("t6_pulses", 32'(donePulses), 32'd1);
    checkOutput("t6_busy_after_done", 32'(busyAfterDone), 32'd0);
    checkSums("t6", 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sad_accumulate.md
SAD_ACCUMULATE -- requirements
Module: sad_accumulate

Interface
REQ-001 Parameter: PIX_W, 8, pixel width; sum width SUM_W = PIX_W+4 (12 at default).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to begin a 16-candidate search; honoured only in IDLE.
REQ-005 abort  in  1  terminates a search in progress; honoured only in ACC.
REQ-006 pix_valid  in  1  cur_pix/ref_pix beat is valid.
REQ-007 pix_ready  out  1  block accepts a beat; a beat transfers when pix_valid && pix_ready.
REQ-008 cur_pix  in  PIX_W  current-block pixel for this beat.
REQ-009 ref_pix  in  PIX_W  reference-window pixel for this beat.
REQ-010 sum0..sum15  out  SUM_W each  registered SAD per candidate, index = {dy[1:0],dx[1:0]}.
REQ-011 done  out  1  one-cycle pulse: sum0..sum15 freshly updated.
REQ-012 busy  out  1  high in ACC and DONE states.

Function
REQ-013 The block SHALL implement FSM states IDLE, ACC, DONE.
REQ-014 IDLE: pix_ready=0; start=1 -> ACC, with beat counter and all 16 working accumulators cleared in the same edge.
REQ-015 ACC: pix_ready=1; each transferred beat SHALL add |cur_pix-ref_pix| (unsigned, PIX_W bits) to working accumulator cand = cnt[7:4].
REQ-016 Beat order SHALL be candidate-major: cnt 0..255, cand = cnt[7:4], pixel = cnt[3:0] of a 4x4 block, raster order.
REQ-017 The counter SHALL advance only on a transfer; pix_valid low cycles SHALL leave all state unchanged.
REQ-018 Transfer with cnt=255 SHALL move ACC -> DONE on that edge.
REQ-019 DONE: sum0..sum15 SHALL load the final working accumulators (including the last beat's contribution) and done=1 for exactly one cycle; next state IDLE.
REQ-020 Latency: done SHALL assert in the cycle immediately following the edge that accepted beat 255.
REQ-021 sum0..sum15 SHALL change only in DONE or reset; they stay stable during a subsequent search.
REQ-022 Accumulators SHALL be SUM_W bits; max 16*255=4080 fits, no saturation logic required.
REQ-023 abort=1 in ACC SHALL return to IDLE next edge, discard working accumulators, leave sum outputs unchanged, no done pulse; a beat transferred in the same cycle is discarded.
REQ-024 start during ACC or DONE SHALL be ignored; start and abort together in IDLE: start wins.
REQ-025 pix_ready SHALL be a registered-state decode (0 in IDLE/DONE), no combinational path from pix_valid.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, cnt=0, working accumulators=0, sum0..sum15=0, done=0, busy=0, pix_ready=0.
REQ-027 Reset asserted mid-search SHALL discard the search; after release the block waits for a new start.

Verification
REQ-028 start, 256 beats cur=ref=0x5A, pix_valid always 1 -> done exactly 257 cycles after start edge, all sums=0.
REQ-029 start, 256 beats cur=255 ref=0 -> all sums=4080 (0xFF0), busy drops the cycle after done.
REQ-030 Candidate c beats use ref=cur-c (cur=100) -> sum_c=16*c (sum15=240); pix_valid toggled every other cycle -> same sums, done 512 cycles after start.
REQ-031 Run search A (all sums 4080), then search B aborted after 100 beats -> sums remain 4080, no done, next start runs normally.
REQ-032 rst pulsed at beat 130, then start, 256 beats cur=10 ref=7 -> sums cleared on reset, then all sums=48.
REQ-033 start pulsed repeatedly during ACC -> ignored, counter unaffected, single done at beat 256.
